// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, FSM states,
// ALU_CONTROL codes, mux selects and the decoded control bundle.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_R_EXEC    = 4'd6,
    ST_R_WB      = 4'd7,
    ST_I_EXEC    = 4'd8,
    ST_I_WB      = 4'd9,
    ST_BRANCH    = 4'd10,
    ST_JUMP      = 4'd11,
    ST_JAL       = 4'd12,
    ST_JR        = 4'd13,
    ST_ILLEGAL   = 4'd14
  } state_t;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_FUNCT = 4'd2;
  localparam logic [3:0] ALU_AND   = 4'd3;
  localparam logic [3:0] ALU_OR    = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] MTR_ALUOUT = 2'd0;
  localparam logic [1:0] MTR_MDR    = 2'd1;
  localparam logic [1:0] MTR_PC     = 2'd2;

  localparam logic [1:0] SRCB_RT      = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  localparam logic [1:0] LS_BYTE = 2'd0;
  localparam logic [1:0] LS_HALF = 2'd1;
  localparam logic [1:0] LS_WORD = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] load_size;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       sign_zero_extend;
    logic [3:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

  function automatic logic [1:0] load_size_of(input logic [5:0] op);
    case (op)
      OP_LB:   return LS_BYTE;
      OP_LH:   return LS_HALF;
      default: return LS_WORD;
    endcase
  endfunction

  function automatic logic [3:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_SLTI: return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational map from controller state (plus held opcode and memory
// handshake) to the datapath control bundle.
module multicycle_control_decode
  import mips_ctrl_pkg::*;
(
  input  state_t      state_i,
  input  logic [5:0]  opcode_i,
  input  logic        ready_i,
  output ctrl_t       ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      ST_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        ctrl_o.ir_write  = ready_i;
        ctrl_o.pc_write  = ready_i;
      end
      ST_DECODE: begin
        ctrl_o.alu_src_b        = SRCB_IMM_SH2;
        ctrl_o.sign_zero_extend = 1'b1;
      end
      ST_MEM_ADDR: begin
        ctrl_o.alu_src_a        = 1'b1;
        ctrl_o.alu_src_b        = SRCB_IMM;
        ctrl_o.sign_zero_extend = 1'b1;
      end
      ST_MEM_READ: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = REGDST_RT;
        ctrl_o.mem_to_reg = MTR_MDR;
        ctrl_o.load_size  = load_size_of(opcode_i);
      end
      ST_MEM_WRITE: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      ST_R_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_RT;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      ST_R_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = REGDST_RD;
      end
      ST_I_EXEC: begin
        ctrl_o.alu_src_a        = 1'b1;
        ctrl_o.alu_src_b        = SRCB_IMM;
        ctrl_o.alu_op           = imm_alu_op(opcode_i);
        ctrl_o.sign_zero_extend = !(opcode_i == OP_ANDI || opcode_i == OP_ORI);
      end
      ST_I_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = REGDST_RT;
      end
      ST_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_RT;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
        ctrl_o.branch_ne     = (opcode_i == OP_BNE);
      end
      ST_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      ST_JAL: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = REGDST_RA;
        ctrl_o.mem_to_reg = MTR_PC;
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PCSRC_JUMP;
      end
      ST_JR: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_RS;
      end
      ST_ILLEGAL: begin
        ctrl_o.illegal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM sequencing the shared-memory, shared-ULA multi-cycle MIPS datapath
// with a ready handshake for variable-latency memory.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE  = ST_FETCH,
  parameter bit     IGNORE_READY = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [1:0] load_size,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       sign_zero_extend,
  output logic [3:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  state_t state_q, state_d;
  ctrl_t  ctrl, ctrl_out;
  logic   ready;
  logic   unused_zero;

  // Branch resolution on zero happens in the datapath via pc_write_cond/branch_ne.
  assign unused_zero = zero;
  assign ready       = IGNORE_READY ? 1'b1 : mem_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:     if (ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:                   state_d = (funct == FN_JR) ? ST_JR : ST_R_EXEC;
          OP_LW, OP_LB, OP_LH, OP_SW: state_d = ST_MEM_ADDR;
          OP_BEQ, OP_BNE:             state_d = ST_BRANCH;
          OP_J:                       state_d = ST_JUMP;
          OP_JAL:                     state_d = ST_JAL;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = ST_I_EXEC;
          default:                    state_d = ST_ILLEGAL;
        endcase
      end
      ST_MEM_ADDR:  state_d = (opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ:  if (ready) state_d = ST_MEM_WB;
      ST_MEM_WRITE: if (ready) state_d = ST_FETCH;
      ST_R_EXEC:    state_d = ST_R_WB;
      ST_I_EXEC:    state_d = ST_I_WB;
      ST_ILLEGAL:   state_d = ST_ILLEGAL;
      default:      state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RESET_STATE;
    else     state_q <= state_d;
  end

  multicycle_control_decode u_decode (
    .state_i  (state_q),
    .opcode_i (opcode),
    .ready_i  (ready),
    .ctrl_o   (ctrl)
  );

  // Reset blanks every output combinationally so in-flight accesses drop at once.
  assign ctrl_out  = rst ? '0 : ctrl;
  assign state_dbg = rst ? '0 : state_q;

  assign pc_write         = ctrl_out.pc_write;
  assign pc_write_cond    = ctrl_out.pc_write_cond;
  assign branch_ne        = ctrl_out.branch_ne;
  assign i_or_d           = ctrl_out.i_or_d;
  assign mem_read         = ctrl_out.mem_read;
  assign mem_write        = ctrl_out.mem_write;
  assign ir_write         = ctrl_out.ir_write;
  assign reg_write        = ctrl_out.reg_write;
  assign reg_dst          = ctrl_out.reg_dst;
  assign mem_to_reg       = ctrl_out.mem_to_reg;
  assign load_size        = ctrl_out.load_size;
  assign alu_src_a        = ctrl_out.alu_src_a;
  assign alu_src_b        = ctrl_out.alu_src_b;
  assign sign_zero_extend = ctrl_out.sign_zero_extend;
  assign alu_op           = ctrl_out.alu_op;
  assign pc_source        = ctrl_out.pc_source;
  assign illegal          = ctrl_out.illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction step-list reference model,
// table-driven latency vectors, random handshake traffic and reset corner cases.
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write;
  logic       ir_write, reg_write, alu_src_a, sign_zero_extend, illegal;
  logic [1:0] reg_dst, mem_to_reg, load_size, alu_src_b, pc_source;
  logic [3:0] alu_op, state_dbg;

  int unsigned checks = 0;
  int unsigned errors = 0;

  multicycle_control #(
    .RESET_STATE  (ST_FETCH),
    .IGNORE_READY (1'b0)
  ) dut (
    .clk (clk), .rst (rst), .opcode (opcode), .funct (funct), .zero (zero),
    .mem_ready (mem_ready), .pc_write (pc_write), .pc_write_cond (pc_write_cond),
    .branch_ne (branch_ne), .i_or_d (i_or_d), .mem_read (mem_read),
    .mem_write (mem_write), .ir_write (ir_write), .reg_write (reg_write),
    .reg_dst (reg_dst), .mem_to_reg (mem_to_reg), .load_size (load_size),
    .alu_src_a (alu_src_a), .alu_src_b (alu_src_b),
    .sign_zero_extend (sign_zero_extend), .alu_op (alu_op),
    .pc_source (pc_source), .illegal (illegal), .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // Instruction phases as described for the datapath, one per clock when ready.
  typedef enum int {
    K_F, K_D, K_ADDR, K_MR, K_MWB, K_MW, K_REX, K_RWB,
    K_IEX, K_IWB, K_BR, K_J, K_JAL, K_JR, K_ILL, K_RST
  } kind_t;

  typedef struct packed {
    logic       pcw, pcwc, bne, iord, mr, mw, irw, rw;
    logic [1:0] rdst, mtr, lsz;
    logic       srca;
    logic [1:0] srcb;
    logic       sze;
    logic [3:0] aop;
    logic [1:0] pcs;
    logic       ill;
    logic       at_fetch;
  } obs_t;

  function automatic obs_t expect_of(input kind_t k, input logic [5:0] op, input logic rdy);
    obs_t o;
    o = '0;
    case (k)
      K_F:    begin o.mr = 1; o.srcb = 2'd1; o.irw = rdy; o.pcw = rdy; o.at_fetch = 1; end
      K_D:    begin o.srcb = 2'd3; o.sze = 1; end
      K_ADDR: begin o.srca = 1; o.srcb = 2'd2; o.sze = 1; end
      K_MR:   begin o.mr = 1; o.iord = 1; end
      K_MWB:  begin
        o.rw = 1; o.mtr = 2'd1;
        o.lsz = (op == 6'h20) ? 2'd0 : (op == 6'h21) ? 2'd1 : 2'd2;
      end
      K_MW:   begin o.mw = 1; o.iord = 1; end
      K_REX:  begin o.srca = 1; o.aop = 4'd2; end
      K_RWB:  begin o.rw = 1; o.rdst = 2'd1; end
      K_IEX:  begin
        o.srca = 1; o.srcb = 2'd2;
        o.aop  = (op == 6'h0C) ? 4'd3 : (op == 6'h0D) ? 4'd4 : (op == 6'h0A) ? 4'd5 : 4'd0;
        o.sze  = !(op == 6'h0C || op == 6'h0D);
      end
      K_IWB:  o.rw = 1;
      K_BR:   begin o.srca = 1; o.aop = 4'd1; o.pcwc = 1; o.pcs = 2'd1; o.bne = (op == 6'h05); end
      K_J:    begin o.pcw = 1; o.pcs = 2'd2; end
      K_JAL:  begin o.rw = 1; o.rdst = 2'd2; o.mtr = 2'd2; o.pcw = 1; o.pcs = 2'd2; end
      K_JR:   begin o.pcw = 1; o.pcs = 2'd3; end
      K_ILL:  o.ill = 1;
      K_RST:  o.at_fetch = 1;
      default: ;
    endcase
    return o;
  endfunction

  function automatic obs_t sample();
    return {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write,
            reg_write, reg_dst, mem_to_reg, load_size, alu_src_a, alu_src_b,
            sign_zero_extend, alu_op, pc_source, illegal, (state_dbg == ST_FETCH)};
  endfunction

  task automatic check_out(input string name, input kind_t k, input logic [5:0] op, input logic rdy);
    obs_t exp_o, act_o;
    exp_o = expect_of(k, op, rdy);
    act_o = sample();
    checks++;
    if (act_o !== exp_o) begin
      errors++;
      $display("FAIL %s op=%h phase=%0d: got %h want %h", name, op, k, act_o, exp_o);
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Called at a negedge; returns at a negedge after the last phase's clock edge.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int unsigned mem_waits,
                           input bit rnd, input int unsigned limit, output int unsigned cycles);
    kind_t steps[$];
    int unsigned p, waits_left;
    logic rdy;
    steps = '{K_F, K_D};
    case (op)
      6'h00: if (fn == 6'h08) steps.push_back(K_JR);
             else begin steps.push_back(K_REX); steps.push_back(K_RWB); end
      6'h20, 6'h21, 6'h23: begin steps.push_back(K_ADDR); steps.push_back(K_MR); steps.push_back(K_MWB); end
      6'h2B: begin steps.push_back(K_ADDR); steps.push_back(K_MW); end
      6'h04, 6'h05: steps.push_back(K_BR);
      6'h02: steps.push_back(K_J);
      6'h03: steps.push_back(K_JAL);
      6'h08, 6'h0A, 6'h0C, 6'h0D: begin steps.push_back(K_IEX); steps.push_back(K_IWB); end
      default: steps.push_back(K_ILL);
    endcase
    p = 0; cycles = 0; waits_left = mem_waits;
    while (p < steps.size() && cycles < limit) begin
      if ((steps[p] == K_MR || steps[p] == K_MW) && waits_left > 0) begin
        rdy = 1'b0; waits_left--;
      end else if (rnd) rdy = ($urandom_range(0, 3) != 0);
      else rdy = 1'b1;
      opcode = op; funct = fn; mem_ready = rdy; zero = 1'($urandom);
      #1;
      check_out("step", steps[p], op, rdy);
      cycles++;
      if (!((steps[p] == K_F || steps[p] == K_MR || steps[p] == K_MW) && !rdy)) p++;
      @(negedge clk);
    end
    if (p < steps.size() && limit >= 100) check_val("timeout", int'(cycles), -1);
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    int unsigned lat;
  } vec_t;

  vec_t        vecs[14];
  logic [5:0]  legal_ops[14];
  int unsigned cyc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{6'h00, 6'h20, 4};  // add $3,$1,$2
    vecs[1]  = '{6'h00, 6'h2A, 4};
    vecs[2]  = '{6'h00, 6'h08, 3};  // jr
    vecs[3]  = '{6'h23, 6'h00, 5};
    vecs[4]  = '{6'h20, 6'h00, 5};
    vecs[5]  = '{6'h21, 6'h00, 5};
    vecs[6]  = '{6'h2B, 6'h00, 4};
    vecs[7]  = '{6'h04, 6'h00, 3};
    vecs[8]  = '{6'h05, 6'h00, 3};
    vecs[9]  = '{6'h02, 6'h00, 3};
    vecs[10] = '{6'h03, 6'h00, 3};
    vecs[11] = '{6'h08, 6'h00, 4};
    vecs[12] = '{6'h0C, 6'h00, 4};
    vecs[13] = '{6'h0A, 6'h00, 4};
    legal_ops = '{6'h00, 6'h00, 6'h23, 6'h20, 6'h21, 6'h2B, 6'h04,
                  6'h05, 6'h02, 6'h03, 6'h08, 6'h0C, 6'h0D, 6'h0A};

    rst = 1'b1; opcode = 6'h3F; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    #1;
    check_out("reset_t0", K_RST, 6'h3F, 1'b1);
    @(negedge clk); #1;
    check_out("reset_held", K_RST, 6'h3F, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_instr(vecs[i].op, vecs[i].fn, 0, 1'b0, 100, cyc);
      check_val($sformatf("latency_op%02h", vecs[i].op), int'(cyc), int'(vecs[i].lat));
    end

    // lb with three memory wait cycles: 5 + 3
    run_instr(6'h20, 6'h00, 3, 1'b0, 100, cyc);
    check_val("lb_wait_latency", int'(cyc), 8);

    for (int n = 0; n < 60; n++) begin
      logic [5:0] op, fn;
      op = legal_ops[$urandom_range(0, 13)];
      fn = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom);
      run_instr(op, fn, $urandom_range(0, 3), 1'b1, 100, cyc);
    end

    // sw caught mid-access by an asynchronous reset
    run_instr(6'h2B, 6'h00, 8, 1'b0, 5, cyc);
    mem_ready = 1'b0; #1;
    check_out("mw_pending", K_MW, 6'h2B, 1'b0);
    #2 rst = 1'b1;
    #1 check_out("rst_mid_write", K_RST, 6'h2B, 1'b0);
    @(negedge clk); #1;
    check_out("rst_mid_write_held", K_RST, 6'h2B, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_instr(6'h00, 6'h20, 0, 1'b0, 100, cyc);
    check_val("after_rst_latency", int'(cyc), 4);

    // illegal opcode is absorbing until reset
    run_instr(6'h3F, 6'h00, 0, 1'b0, 100, cyc);
    for (int n = 0; n < 19; n++) begin
      opcode = 6'($urandom); mem_ready = 1'($urandom); #1;
      check_out("illegal_hold", K_ILL, opcode, mem_ready);
      @(negedge clk);
    end
    #3 rst = 1'b1;
    #1 check_out("illegal_rst", K_RST, opcode, mem_ready);
    @(negedge clk);
    rst = 1'b0;
    run_instr(6'h05, 6'h00, 0, 1'b0, 100, cyc);
    check_val("post_illegal_bne", int'(cyc), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style FSM that sequences a multi-cycle MIPS datapath.
- The datapath is built from the team's existing blocks: PC REGISTER, one unified IMEM/DMEM memory port, REGISTER_BANK, EXTEND, ULA, ALU_CONTROL and MUX21/MUX41.
- Replaces the single-cycle CONTROL block, so one memory and one ULA are shared across FETCH/DECODE/EXEC/MEM/WB steps.
- Supports a variable-latency memory through a ready handshake.

Parameters:
- RESET_STATE, FETCH: state entered on reset.
- IGNORE_READY, 0: when 1, mem_ready is treated as constant 1 (single-cycle memory model).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  instruction register [31:26]
- funct  in  6  instruction register [5:0]
- zero  in  1  ULA zero flag
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if branch condition holds
- branch_ne  out  1  condition is !zero (bne) instead of zero (beq)
- i_or_d  out  1  memory address: 0 = PC, 1 = ALU-out register
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- reg_write  out  1  register bank write
- reg_dst  out  2  write address: 0 = rt, 1 = rd, 2 = 31
- mem_to_reg  out  2  write data: 0 = ALU-out, 1 = MDR, 2 = PC (pc+4 already loaded)
- load_size  out  2  0 = byte, 1 = half, 2 = word (zero-extend selector)
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  0 = rt, 1 = constant 4, 2 = extended imm, 3 = extended imm << 2
- sign_zero_extend  out  1  1 = sign-extend, 0 = zero-extend
- alu_op  out  4  code to ALU_CONTROL: 0 = ADD, 1 = SUB, 2 = FUNCT, 3 = AND, 4 = OR, 5 = SLT
- pc_source  out  2  0 = ALU result, 1 = ALU-out register, 2 = jump target, 3 = rs (jr)
- illegal  out  1  unsupported opcode trapped
- state_dbg  out  4  current state encoding

Behaviour:
- Reset: rst high asynchronously forces state = FETCH. While rst is high, every output is 0, including alu_op and all selects.
- Outputs are decoded combinationally from the state register.
- Every enable (pc_write, ir_write, reg_write, pc_write_cond) is additionally gated by mem_ready where listed.
- FETCH:
  - Drives mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 1, alu_op = ADD, pc_source = 0.
  - ir_write and pc_write are asserted only when mem_ready = 1; the state holds while mem_ready = 0.
  - mem_ready = 1 -> DECODE.
- DECODE:
  - Computes the branch target: alu_src_a = 0, alu_src_b = 3, alu_op = ADD, sign_zero_extend = 1.
  - Next state by opcode:
    - 0x00 with funct 0x08 -> JR; other 0x00 -> R_EXEC.
    - 0x23/0x20/0x21 (lw/lb/lh) and 0x2B (sw) -> MEM_ADDR.
    - 0x04/0x05 -> BRANCH.
    - 0x02 -> JUMP; 0x03 -> JAL.
    - 0x08/0x0C/0x0D/0x0A (addi/andi/ori/slti) -> I_EXEC.
    - anything else -> ILLEGAL.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 2, ADD, sign-extend. Loads -> MEM_READ; sw -> MEM_WRITE.
- MEM_READ: mem_read = 1, i_or_d = 1. Holds until mem_ready, then -> MEM_WB.
- MEM_WB:
  - reg_write = 1, reg_dst = 0, mem_to_reg = 1.
  - load_size from opcode: lb = 0, lh = 1, lw = 2.
  - -> FETCH.
- MEM_WRITE: mem_write = 1, i_or_d = 1. Holds until mem_ready, then -> FETCH.
- R_EXEC: alu_src_a = 1, alu_src_b = 0, alu_op = FUNCT -> R_WB.
- R_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0 -> FETCH.
- I_EXEC:
  - alu_src_a = 1, alu_src_b = 2.
  - alu_op: ADD/AND/OR/SLT per opcode.
  - sign_zero_extend = 0 for andi/ori, 1 otherwise.
  - -> I_WB.
- I_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0 -> FETCH.
- BRANCH:
  - alu_src_a = 1, alu_src_b = 0, SUB, pc_write_cond = 1, pc_source = 1.
  - branch_ne = 1 for opcode 0x05.
  - -> FETCH.
- JUMP: pc_write = 1, pc_source = 2 -> FETCH.
- JAL: reg_write = 1, reg_dst = 2, mem_to_reg = 2, pc_write = 1, pc_source = 2 -> FETCH.
- JR: pc_write = 1, pc_source = 3 -> FETCH.
- ILLEGAL: illegal = 1, all enables 0. Absorbing state; only rst exits.
- Opcode and funct are sampled only in DECODE. Later states use opcode as held in the IR, which is stable because ir_write is 0 outside FETCH.
- Latency with mem_ready constant 1: R/I-type 4 cycles; lw/lb/lh 5; sw 4; beq/bne 3; j/jal/jr 3. Each wait cycle with mem_ready = 0 adds 1.
- Reset mid-access: any in-flight mem_read/mem_write drops to 0 immediately; no write enable is asserted afterwards.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode/funct constants
  - state enum (4-bit)
  - alu_op codes
  - reg_dst, mem_to_reg, alu_src_b, pc_source and load_size encodings
- One sub-module, multicycle_control_decode: purely combinational map (state, opcode, mem_ready) -> output bundle. The top holds the state register and next-state logic.

Test Plan:
- add $3,$1,$2 (0x00221820), mem_ready = 1 -> states FETCH, DECODE, R_EXEC, R_WB; reg_write = 1, reg_dst = 1 only in cycle 4; alu_op = 2 in R_EXEC.
- lb (opcode 0x20), mem_ready low for 3 cycles in MEM_READ -> state held 3 extra cycles with mem_read = 1, i_or_d = 1; MEM_WB shows load_size = 0, mem_to_reg = 1; total 8 cycles.
- bne with zero = 0 -> BRANCH asserts pc_write_cond = 1, branch_ne = 1, pc_source = 1; back in FETCH at cycle 4.
- jal -> JAL asserts reg_dst = 2, mem_to_reg = 2, reg_write = 1, pc_write = 1, pc_source = 2.
- Opcode 0x3F -> ILLEGAL; illegal = 1 held for 20 cycles with no enables; rst pulse -> FETCH, illegal = 0.
- rst asserted asynchronously mid-MEM_WRITE (mem_write = 1) -> mem_write = 0 in the same cycle, state_dbg = FETCH encoding; after release, fetch restarts with mem_read = 1.
